// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token encodings (also used by the encoder)
// and the receiver lock-state encoding.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: control-token match, 10b->8b data
// recovery and the transition-minimisation consistency check.
module tmds_symbol_decode (
  input  logic [9:0] tmds_i,
  output logic       is_ctrl_o,
  output logic [1:0] cd_o,
  output logic [7:0] vd_o,
  output logic       err_o
);
  import tmds_pkg::*;

  logic [7:0] d;
  logic [7:0] vd;
  logic [3:0] n1;
  logic       use_xnor;

  always_comb begin
    is_ctrl_o = 1'b1;
    cd_o      = '0;
    case (tmds_i)
      CTRL_TOKEN_00: cd_o = 2'b00;
      CTRL_TOKEN_01: cd_o = 2'b01;
      CTRL_TOKEN_10: cd_o = 2'b10;
      CTRL_TOKEN_11: cd_o = 2'b11;
      default:       is_ctrl_o = 1'b0;
    endcase

    d     = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0];
    vd    = '0;
    vd[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      vd[i] = tmds_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end

    // The encoder's XOR/XNOR choice is a function of the data, so bit 8 must agree.
    n1       = ones8(vd);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !vd[0]);
    err_o    = !is_ctrl_o && (tmds_i[8] != !use_xnor);
    vd_o     = vd;
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: registered symbol decode, error counting, and
// symbol-alignment lock FSM that requests deserializer bit slips.
module tmds_decoder #(
  parameter int unsigned CTRL_RUN     = 16,
  parameter int unsigned SLIP_TIMEOUT = 1024,
  parameter int unsigned SLIP_WAIT    = 8,
  parameter int unsigned ERR_LIMIT    = 8,
  parameter int unsigned ERR_WIN      = 1024
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [9:0]  tmds_i,
  output logic [7:0]  vd_o,
  output logic [1:0]  cd_o,
  output logic        vde_o,
  output logic        err_o,
  output logic        locked_o,
  output logic        bitslip_o,
  output logic [15:0] err_cnt_o
);
  import tmds_pkg::*;

  localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int unsigned TMO_W  = $clog2(SLIP_TIMEOUT + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int unsigned WIN_W  = $clog2(ERR_WIN + 1);
  localparam int unsigned ERR_W  = $clog2(ERR_LIMIT + 1);

  logic       sym_is_ctrl;
  logic [1:0] sym_cd;
  logic [7:0] sym_vd;
  logic       sym_err;

  tmds_symbol_decode u_decode (
    .tmds_i    (tmds_i),
    .is_ctrl_o (sym_is_ctrl),
    .cd_o      (sym_cd),
    .vd_o      (sym_vd),
    .err_o     (sym_err)
  );

  lock_state_e state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d, run_inc;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [ERR_W-1:0]  win_err_q, win_err_d, win_err_inc;
  logic              win_wrap;
  logic              bitslip_q, bitslip_d;
  logic [7:0]        vd_q, vd_d;
  logic [1:0]        cd_q, cd_d;
  logic              vde_q, vde_d;
  logic              err_q, err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  always_comb begin
    vd_d      = vd_q;
    cd_d      = cd_q;
    vde_d     = vde_q;
    err_d     = sym_err;
    err_cnt_d = err_cnt_q;
    if (sym_is_ctrl) begin
      cd_d  = sym_cd;
      vde_d = 1'b0;
    end else begin
      vd_d  = sym_vd;
      vde_d = 1'b1;
    end
    if (sym_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    tmo_d       = tmo_q;
    wait_d      = wait_q;
    win_d       = win_q;
    win_err_d   = win_err_q;
    bitslip_d   = 1'b0;
    run_inc     = sym_is_ctrl ? run_q + RUN_W'(1) : '0;
    win_err_inc = win_err_q + ERR_W'(sym_err);
    win_wrap    = (win_q == WIN_W'(ERR_WIN - 1));

    case (state_q)
      SEARCH: begin
        run_d = run_inc;
        tmo_d = tmo_q + TMO_W'(1);
        // Lock is tested first so a run completing on the timeout symbol wins.
        if (run_inc == RUN_W'(CTRL_RUN)) begin
          state_d   = LOCKED;
          run_d     = '0;
          tmo_d     = '0;
          win_d     = '0;
          win_err_d = '0;
        end else if (tmo_q == TMO_W'(SLIP_TIMEOUT - 1)) begin
          state_d   = SLIP;
          bitslip_d = 1'b1;
          run_d     = '0;
          tmo_d     = '0;
          wait_d    = '0;
        end
      end
      SLIP: begin
        if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
          state_d = SEARCH;
          wait_d  = '0;
          run_d   = '0;
          tmo_d   = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      LOCKED: begin
        win_d = win_wrap ? '0 : win_q + WIN_W'(1);
        if (win_err_inc == ERR_W'(ERR_LIMIT)) begin
          state_d   = SEARCH;
          run_d     = '0;
          tmo_d     = '0;
          win_d     = '0;
          win_err_d = '0;
        end else if (win_wrap) begin
          win_err_d = '0;
        end else begin
          win_err_d = win_err_inc;
        end
      end
      default: begin
        state_d = SEARCH;
        run_d   = '0;
        tmo_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= SEARCH;
      run_q     <= '0;
      tmo_q     <= '0;
      wait_q    <= '0;
      win_q     <= '0;
      win_err_q <= '0;
      bitslip_q <= 1'b0;
      vd_q      <= '0;
      cd_q      <= '0;
      vde_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      tmo_q     <= tmo_d;
      wait_q    <= wait_d;
      win_q     <= win_d;
      win_err_q <= win_err_d;
      bitslip_q <= bitslip_d;
      vd_q      <= vd_d;
      cd_q      <= cd_d;
      vde_q     <= vde_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign vd_o      = vd_q;
  assign cd_o      = cd_q;
  assign vde_o     = vde_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
  assign bitslip_o = bitslip_q;
  assign locked_o  = (state_q == LOCKED);

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reference TMDS encoder feeds a scoreboard
// of expected decodes; lock, slip and error-count behaviour checked at set points.
module tb_tmds_decoder;

  logic        clk;
  logic        rst_i;
  logic [9:0]  tmds_i;
  logic [7:0]  vd_o;
  logic [1:0]  cd_o;
  logic        vde_o;
  logic        err_o;
  logic        locked_o;
  logic        bitslip_o;
  logic [15:0] err_cnt_o;

  tmds_decoder #(
    .CTRL_RUN     (16),
    .SLIP_TIMEOUT (1024),
    .SLIP_WAIT    (8),
    .ERR_LIMIT    (8),
    .ERR_WIN      (1024)
  ) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .tmds_i    (tmds_i),
    .vd_o      (vd_o),
    .cd_o      (cd_o),
    .vde_o     (vde_o),
    .err_o     (err_o),
    .locked_o  (locked_o),
    .bitslip_o (bitslip_o),
    .err_cnt_o (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       err;
  } obs_t;

  obs_t        sb[$];
  int unsigned pass_cnt  = 0;
  int unsigned fail_cnt  = 0;
  int unsigned total_cnt = 0;
  logic [7:0]  held_vd;
  logic [1:0]  held_cd;
  logic [15:0] exp_errcnt;
  int unsigned since_lock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference DVI encoder (without DC balancing; inversion chosen by caller).
  function automatic logic [9:0] encode(input logic [7:0] d, input logic inv);
    int unsigned n1;
    logic [8:0]  qm;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += d[i];
    qm    = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  task automatic step(input logic [9:0] sym, input obs_t e);
    obs_t got;
    obs_t want;
    tmds_i = sym;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got  = {vd_o, cd_o, vde_o, err_o};
    want = sb.pop_front();
    chk("decode", 32'(got), 32'(want));
    since_lock++;
  endtask

  task automatic send_ctrl(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = 10'h354;
      2'b01:   tok = 10'h0AB;
      2'b10:   tok = 10'h154;
      default: tok = 10'h2AB;
    endcase
    held_cd = c;
    step(tok, '{vd: held_vd, cd: c, vde: 1'b0, err: 1'b0});
  endtask

  task automatic send_raw(input logic [9:0] sym, input logic [7:0] d, input logic e);
    held_vd = d;
    if (e) exp_errcnt++;
    step(sym, '{vd: d, cd: held_cd, vde: 1'b1, err: e});
  endtask

  task automatic send_data(input logic [7:0] d, input logic inv);
    send_raw(encode(d, inv), d, 1'b0);
  endtask

  task automatic send_rand();
    send_data(8'($urandom), 1'($urandom));
  endtask

  task automatic send_bad();
    send_raw(10'h155, 8'hFF, 1'b1);
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    tmds_i = 10'h155;
    sb.delete();
    @(posedge clk);
    #1;
    chk("reset_outputs",
        32'({vd_o, cd_o, vde_o, err_o, locked_o, bitslip_o, err_cnt_o}), 32'd0);
    rst_i      = 1'b0;
    held_vd    = '0;
    held_cd    = '0;
    exp_errcnt = '0;
  endtask

  task automatic lock_with(input logic [1:0] c);
    for (int i = 0; i < 15; i++) send_ctrl(c);
    chk("not_locked_15", 32'(locked_o), 32'd0);
    send_ctrl(c);
    chk("locked_16", 32'(locked_o), 32'd1);
    since_lock = 0;
  endtask

  initial begin
    rst_i      = 1'b1;
    tmds_i     = '0;
    since_lock = 0;
    do_reset();
    do_reset();

    // Error detection and counting outside lock, then basic data decode.
    send_bad();
    chk("errcnt_search", 32'(err_cnt_o), 32'(exp_errcnt));
    send_raw(10'h100, 8'h00, 1'b0);
    send_raw(10'h0FF, 8'hFF, 1'b0);
    chk("errcnt_hold", 32'(err_cnt_o), 32'(exp_errcnt));

    lock_with(2'b00);

    send_ctrl(2'b01);
    send_ctrl(2'b10);
    send_ctrl(2'b11);
    for (int i = 0; i < 20; i++) send_rand();
    send_bad();
    chk("errcnt_locked", 32'(err_cnt_o), 32'(exp_errcnt));
    send_rand();
    for (int i = 0; i < 6; i++) send_bad();
    chk("hold_after_7", 32'(locked_o), 32'd1);
    send_bad();
    chk("drop_after_8", 32'(locked_o), 32'd0);
    chk("errcnt_8", 32'(err_cnt_o), 32'(exp_errcnt));

    // Eighth error landing on the window-wrap symbol still drops lock.
    lock_with(2'b11);
    for (int i = 0; i < 7; i++) send_bad();
    while (since_lock < 1023) send_rand();
    chk("hold_before_wrap", 32'(locked_o), 32'd1);
    send_bad();
    chk("drop_on_wrap", 32'(locked_o), 32'd0);

    // Seven errors, wrap, one more: lock held.
    lock_with(2'b10);
    for (int i = 0; i < 7; i++) send_bad();
    while (since_lock < 1024) send_rand();
    send_bad();
    chk("hold_after_wrap", 32'(locked_o), 32'd1);
    chk("errcnt_wrap", 32'(err_cnt_o), 32'(exp_errcnt));

    // Mid-lock reset and relock.
    do_reset();
    lock_with(2'b01);

    // Bit slip cadence: 1024 symbols, 8 idle cycles, 1024 symbols.
    do_reset();
    for (int n = 1; n <= 2060; n++) begin
      send_rand();
      chk("bitslip", 32'(bitslip_o), 32'(n == 1024 || n == 2056));
      if (n == 1025) chk("slip_unlocked", 32'(locked_o), 32'd0);
    end

    // Reset during SLIP: no leftover pulse, fresh timeout.
    do_reset();
    for (int n = 1; n <= 1027; n++) begin
      send_rand();
      if (n == 1023 || n == 1024 || n == 1025) chk("bitslip_pre", 32'(bitslip_o), 32'(n == 1024));
    end
    do_reset();
    for (int n = 1; n <= 1024; n++) begin
      send_rand();
      if (n <= 2 || n >= 1023) chk("bitslip_post", 32'(bitslip_o), 32'(n == 1024));
    end

    // Lock completing on the timeout symbol beats the slip.
    do_reset();
    for (int n = 1; n <= 1008; n++) send_rand();
    for (int n = 0; n < 16; n++) send_ctrl(2'b00);
    chk("tie_locked", 32'(locked_o), 32'd1);
    chk("tie_no_slip", 32'(bitslip_o), 32'd0);
    for (int n = 0; n < 4; n++) begin
      send_rand();
      chk("tie_no_slip_after", 32'(bitslip_o), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
